// File: rtl/ex_mem_buf_pkg.sv
// Shared constants for the EX->MEM buffer: default bus widths, bubble field values,
// and the pointer-width helper.
package ex_mem_buf_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_OP_W   = 8;
  localparam int unsigned NOP_WD     = 0;
  localparam int unsigned NOP_OP     = 0;

  // A one-entry buffer still gets a 1-bit pointer so no vector is zero-width.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ex_mem_fifo_core.sv
// In-order DEPTH-entry storage with read/write pointers and occupancy count.
// The storage is visible as a whole so the top can run a forwarding search over it.
module ex_mem_fifo_core
  import ex_mem_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 78
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             push,
  input  logic                             pop,
  input  logic [W-1:0]                     wr_data,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic [ptr_w(DEPTH)-1:0]          rd_ptr,
  output logic [DEPTH-1:0][W-1:0]          slots
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [DEPTH-1:0][W-1:0] slots_q;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointer and count next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Reset and flush both return the buffer to empty.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage needs no reset: unoccupied slots are never exposed.
  always_ff @(posedge clk) begin
    if (push) slots_q[wr_ptr_q] <= wr_data;
  end

  assign count  = count_q;
  assign rd_ptr = rd_ptr_q;
  assign slots  = slots_q;

endmodule

// File: rtl/ex_mem_buf.sv
// EX->MEM pipeline buffer: valid/ready handshake in front of an in-order FIFO,
// bubble-clean head outputs, and youngest-first register forwarding lookup.
module ex_mem_buf
  import ex_mem_buf_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned OP_W         = DEF_OP_W,
  parameter int unsigned OP_NOP       = NOP_OP,
  parameter bit          READY_BYPASS = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ADDR_W-1:0]           in_wd,
  input  logic                        in_wreg,
  input  logic [DATA_W-1:0]           in_wdata,
  input  logic [DATA_W-1:0]           in_mdata,
  input  logic [OP_W-1:0]             in_op,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ADDR_W-1:0]           out_wd,
  output logic                        out_wreg,
  output logic [DATA_W-1:0]           out_wdata,
  output logic [DATA_W-1:0]           out_mdata,
  output logic [OP_W-1:0]             out_op,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  input  logic [ADDR_W-1:0]           fwd_raddr,
  output logic                        fwd_hit,
  output logic [DATA_W-1:0]           fwd_data
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] mdata;
    logic [OP_W-1:0]   op;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

  logic                          full, push, pop;
  logic [CNT_W-1:0]              count_w;
  logic [PTR_W-1:0]              rd_ptr;
  logic [DEPTH-1:0][ENTRY_W-1:0] slots;
  entry_t                        wr_entry, head;

  assign full      = (count_w == CNT_W'(DEPTH));
  assign out_valid = (count_w != '0);
  assign in_ready  = READY_BYPASS ? (!full || out_ready) : !full;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign count     = count_w;

  assign wr_entry = '{wd: in_wd, wreg: in_wreg, wdata: in_wdata, mdata: in_mdata, op: in_op};

  ex_mem_fifo_core #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .count   (count_w),
    .rd_ptr  (rd_ptr),
    .slots   (slots)
  );

  // Head mux: an empty buffer presents a clean bubble rather than stale fields.
  always_comb begin
    head      = entry_t'(slots[rd_ptr]);
    out_wd    = '0;
    out_wreg  = 1'b0;
    out_wdata = '0;
    out_mdata = '0;
    out_op    = OP_W'(OP_NOP);
    if (out_valid) begin
      out_wd    = head.wd;
      out_wreg  = head.wreg;
      out_wdata = head.wdata;
      out_mdata = head.mdata;
      out_op    = head.op;
    end
  end

  // Walk occupied entries oldest to youngest; a later match overrides an earlier one.
  always_comb begin
    logic [PTR_W:0] idx;
    entry_t         e;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    e        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = {1'b0, rd_ptr} + (PTR_W + 1)'(i);
      if (idx >= (PTR_W + 1)'(DEPTH)) idx = idx - (PTR_W + 1)'(DEPTH);
      e = entry_t'(slots[idx[PTR_W-1:0]]);
      if ((CNT_W'(i) < count_w) && e.wreg && (e.wd == fwd_raddr) && (fwd_raddr != '0)) begin
        fwd_hit  = 1'b1;
        fwd_data = e.wdata;
      end
    end
  end

endmodule
